pps_gen: RTL and testbench
==========================

PPS_GEN -- requirements
Module: pps_gen

Interface
REQ-001 SHALL have parameter PERIOD, default 10_000_000, meaning CLK_SYS cycles per output second.
REQ-002 SHALL have parameter PULSE, default 1_000_000, meaning PPS_OUT high time in cycles; 1 <= PULSE < PERIOD.
REQ-003 SHALL have parameter CNT_W, default 24, meaning phase counter width; PERIOD <= 2^CNT_W.
REQ-004 SHALL have parameter TOL, default 1000, meaning max accepted |phase error| and holdover slack, in cycles.
REQ-005 SHALL have port CLK_SYS, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port CLK_RST, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port PPS_REF, input, 1 bit: asynchronous GPS 1PPS reference.
REQ-008 SHALL have port ARM, input, 1 bit: level enable; start condition (preheat done).
REQ-009 SHALL have port DIV_RST, input, 1 bit: asynchronous stop request; rising edge acts.
REQ-010 SHALL have port MODE, input, 2 bits: 00 one-shot align, 01 track, 10 free-run, 11 treated as 00.
REQ-011 SHALL have port PPS_OUT, output, 1 bit: registered local 1PPS.
REQ-012 SHALL have port PHASE_ERR, output, CNT_W+1 bits signed: last measured reference phase.
REQ-013 SHALL have port PHASE_VALID, output, 1 bit: one-cycle strobe, PHASE_ERR updated.
REQ-014 SHALL have port OUTLIER, output, 1 bit: one-cycle strobe, measurement exceeded TOL.
REQ-015 SHALL have port HOLDOVER, output, 1 bit: level, track mode running without reference.
REQ-016 SHALL have port STATE, output, 2 bits: 00 IDLE, 01 WAIT_REF, 10 RUN, 11 HOLD.

Function
REQ-017 SHALL pass PPS_REF and DIV_RST each through a 2-flop synchroniser; ref_rise / rst_rise = one-cycle rising-edge detects on the synchronised signals.
REQ-018 SHALL register MODE on IDLE exit; MODE changes ignored until next IDLE.
REQ-019 IDLE: phase counter 0, PPS_OUT 0; when ARM=1 go to RUN if MODE=10, else WAIT_REF.
REQ-020 WAIT_REF: on ref_rise go to RUN; the ref_rise cycle is phase 0.
REQ-021 RUN/HOLD: phase counter increments each cycle, wraps PERIOD-1 -> 0.
REQ-022 PPS_OUT SHALL be high on the cycle after phase 0 and remain high exactly PULSE cycles, repeating every PERIOD cycles.
REQ-023 On ref_rise in RUN/HOLD: phase p -> PHASE_ERR = p if p < PERIOD/2, else p - PERIOD; PHASE_VALID pulses the next cycle; all modes.
REQ-024 |PHASE_ERR| > TOL SHALL pulse OUTLIER with PHASE_VALID; no realign, holdover timer not restarted.
REQ-025 Track mode, non-outlier ref_rise: that cycle becomes phase 0 (realign), holdover timer restarts, HOLD -> RUN.
REQ-026 One-shot and free-run: measurement only, never realign; HOLDOVER stays 0.
REQ-027 Track mode: holdover timer counts cycles since last accepted ref_rise; reaching PERIOD+TOL -> state HOLD, HOLDOVER=1, free-run continues unchanged.
REQ-028 rst_rise or ARM=0 -> IDLE from any state next cycle; PPS_OUT 0; PHASE_ERR held; rst_rise wins over a coincident ref_rise.
REQ-029 Realign during PPS_OUT high SHALL restart the pulse: high for PULSE cycles after the new phase 0, no low glitch.
REQ-030 Arithmetic SHALL be CNT_W+1 bits signed, no overflow for any legal PERIOD.

Reset
REQ-031 CLK_RST low SHALL asynchronously force STATE=IDLE, counters 0, PPS_OUT/PHASE_VALID/OUTLIER/HOLDOVER 0, PHASE_ERR 0, synchronisers 0.
REQ-032 Release SHALL take effect on the next CLK_SYS edge; no PPS_OUT until ARM and (MODE=10 or ref_rise).

Verification (PERIOD=100, PULSE=10, TOL=3)
REQ-033 Reset mid-pulse -> PPS_OUT 0 immediately, STATE=00, all strobes 0.
REQ-034 MODE=00, ARM=1, PPS_REF rises at cycle T -> PPS_OUT high T+3..T+12; next ref at T+100 -> PHASE_ERR=0, PHASE_VALID 1 cycle.
REQ-035 MODE=01, ref 2 cycles late -> PHASE_ERR=+2, PPS_OUT shifted 2 later; ref 3 early -> PHASE_ERR=-3; ref 5 late -> OUTLIER, no shift.
REQ-036 MODE=01, ref removed -> HOLDOVER=1 exactly 103 cycles after last accepted ref_rise, PPS_OUT still every 100; ref returns -> HOLDOVER=0, realigned.
REQ-037 DIV_RST edge and ref_rise same cycle in RUN -> IDLE, PPS_OUT 0 next cycle; then MODE=10 with ARM=1 -> PPS_OUT with no reference.

Source files
------------

// File: rtl/pps_gen.sv
// Local 1PPS generator that aligns to a GPS reference, measures its phase,
// rejects outliers and free-runs through reference loss (holdover).
module pps_gen #(
  parameter int PERIOD = 10_000_000,
  parameter int PULSE  = 1_000_000,
  parameter int CNT_W  = 24,
  parameter int TOL    = 1000
) (
  input  logic                  CLK_SYS,
  input  logic                  CLK_RST,
  input  logic                  PPS_REF,
  input  logic                  ARM,
  input  logic                  DIV_RST,
  input  logic [1:0]            MODE,
  output logic                  PPS_OUT,
  output logic signed [CNT_W:0] PHASE_ERR,
  output logic                  PHASE_VALID,
  output logic                  OUTLIER,
  output logic                  HOLDOVER,
  output logic [1:0]            STATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_REF = 2'b01,
    S_RUN      = 2'b10,
    S_HOLD     = 2'b11
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_TRACK   = 2'b01;
  localparam logic [1:0] MODE_FREE    = 2'b10;

  localparam logic [CNT_W-1:0]   PH_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]   PH_HALF  = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0]   PH_PULSE = CNT_W'(PULSE);
  localparam logic signed [CNT_W:0] PERIOD_S = (CNT_W+1)'(PERIOD);
  localparam logic signed [CNT_W:0] TOL_S    = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]     HO_LIM   = (CNT_W+1)'(PERIOD + TOL);

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_W-1:0]      phase_q, phase_d;
  logic [CNT_W:0]        ho_q, ho_d, ho_inc;
  logic                  pps_q, pps_d;
  logic                  valid_q, valid_d;
  logic                  outlier_q, outlier_d;
  logic signed [CNT_W:0] err_q, err_d, err_calc, err_abs;
  logic [2:0]            ref_sync_q, ref_sync_d;
  logic [2:0]            rst_sync_q, rst_sync_d;
  logic                  ref_rise, rst_rise, stop, running, meas, accept, out_calc, entering;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_ONESHOT;
      phase_q    <= '0;
      ho_q       <= '0;
      pps_q      <= 1'b0;
      valid_q    <= 1'b0;
      outlier_q  <= 1'b0;
      err_q      <= '0;
      ref_sync_q <= '0;
      rst_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      ho_q       <= ho_d;
      pps_q      <= pps_d;
      valid_q    <= valid_d;
      outlier_q  <= outlier_d;
      err_q      <= err_d;
      ref_sync_q <= ref_sync_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // Bit 0/1 form the synchroniser; bit 2 is the previous value for edge detect.
  always_comb begin
    ref_sync_d = {ref_sync_q[1:0], PPS_REF};
    rst_sync_d = {rst_sync_q[1:0], DIV_RST};
    ref_rise   = ref_sync_q[1] & ~ref_sync_q[2];
    rst_rise   = rst_sync_q[1] & ~rst_sync_q[2];
    stop       = rst_rise | ~ARM;
    running    = (state_q == S_RUN) || (state_q == S_HOLD);
    meas       = running & ref_rise & ~stop;
    err_calc   = (phase_q < PH_HALF) ? $signed({1'b0, phase_q})
                                     : $signed({1'b0, phase_q}) - PERIOD_S;
    err_abs    = err_calc[CNT_W] ? -err_calc : err_calc;
    out_calc   = err_abs > TOL_S;
    accept     = meas & (mode_q == MODE_TRACK) & ~out_calc;
    ho_inc     = (ho_q == HO_LIM) ? ho_q : ho_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     state_d = (MODE == MODE_FREE) ? S_RUN : S_WAIT_REF;
        S_WAIT_REF: if (ref_rise) state_d = S_RUN;
        S_RUN:      if (!accept && (mode_q == MODE_TRACK) && (ho_inc == HO_LIM)) state_d = S_HOLD;
        S_HOLD:     if (accept) state_d = S_RUN;
      endcase
    end
  end

  // The cycle that starts or realigns the second is phase 0, so the next phase is 1.
  always_comb begin
    mode_d   = mode_q;
    entering = ((state_q == S_IDLE) || (state_q == S_WAIT_REF)) && (state_d == S_RUN);
    if ((state_q == S_IDLE) && (state_d != S_IDLE))
      mode_d = (MODE == 2'b11) ? MODE_ONESHOT : MODE;
    if ((state_d == S_IDLE) || (state_d == S_WAIT_REF)) begin
      phase_d = '0;
      ho_d    = '0;
    end else if (entering || accept) begin
      phase_d = CNT_W'(1);
      ho_d    = '0;
    end else begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      ho_d    = ho_inc;
    end
    pps_d     = ((state_d == S_RUN) || (state_d == S_HOLD)) &&
                (phase_d != '0) && (phase_d <= PH_PULSE);
    err_d     = meas ? err_calc : err_q;
    valid_d   = meas;
    outlier_d = meas & out_calc;
  end

  always_comb begin
    PPS_OUT     = pps_q;
    PHASE_ERR   = err_q;
    PHASE_VALID = valid_q;
    OUTLIER     = outlier_q;
    HOLDOVER    = (state_q == S_HOLD);
    STATE       = state_q;
  end

endmodule

// File: tb/tb_pps_gen.sv
// Directed bench for pps_gen with PERIOD=100, PULSE=10, TOL=3: one-shot,
// track/holdover, coincident stop, free-run and mid-pulse reset.
module tb_pps_gen;
  localparam int PERIOD = 100;
  localparam int PULSE  = 10;
  localparam int CNT_W  = 8;
  localparam int TOL    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pps_ref = 1'b0;
  logic arm = 1'b0;
  logic div_rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic pps_out;
  logic signed [CNT_W:0] phase_err;
  logic phase_valid, outlier, holdover;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = -1;
  int last_fall = -1;
  int last_len = -1;
  int ho_rise = -1;
  logic pps_prev = 1'b0;
  logic ho_prev = 1'b0;
  logic [CNT_W+1:0] exp_q[$];
  logic [CNT_W+1:0] e;
  int base, n, r, f;

  pps_gen #(.PERIOD(PERIOD), .PULSE(PULSE), .CNT_W(CNT_W), .TOL(TOL)) dut (
    .CLK_SYS    (clk),
    .CLK_RST    (rst_n),
    .PPS_REF    (pps_ref),
    .ARM        (arm),
    .DIV_RST    (div_rst),
    .MODE       (mode),
    .PPS_OUT    (pps_out),
    .PHASE_ERR  (phase_err),
    .PHASE_VALID(phase_valid),
    .OUTLIER    (outlier),
    .HOLDOVER   (holdover),
    .STATE      (state)
  );

  // clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=%0t required<500000", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Reference pulse driven right after edge c; ref_rise acts on edge c+3.
  task automatic send_ref(input int c, input int err, input bit out, input bit measured);
    wait_until(c);
    pps_ref = 1'b1;
    if (measured) exp_q.push_back({out, (CNT_W+1)'(err)});
    tick(4);
    pps_ref = 1'b0;
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (pps_out && !pps_prev) last_rise = cyc;
    if (!pps_out && pps_prev) begin
      last_fall = cyc;
      last_len  = cyc - last_rise;
    end
    if (holdover && !ho_prev) ho_rise = cyc;
    pps_prev = pps_out;
    ho_prev  = holdover;
    if (phase_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", int'(phase_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("phase_err", int'(phase_err), int'($signed(e[CNT_W:0])));
        check("outlier", int'(outlier), int'(e[CNT_W+1]));
      end
    end else if (outlier) begin
      check("outlier_has_valid", int'(phase_valid), 1);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_pps", int'(pps_out), 0);
    check("rst_valid", int'(phase_valid), 0);
    check("rst_outlier", int'(outlier), 0);
    check("rst_holdover", int'(holdover), 0);
    check("rst_err", int'(phase_err), 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_arm", int'(state), 0);

    // one-shot align
    mode = 2'b00; arm = 1'b1;
    tick(2);
    check("wait_ref_state", int'(state), 1);
    tick(20);
    check("no_pps_without_ref", last_rise, -1);
    base = cyc + 2;
    send_ref(base, 0, 1'b0, 1'b0);
    wait_until(base + 15);
    check("oneshot_rise", last_rise, base + 3);
    check("oneshot_len", last_len, PULSE);
    check("oneshot_run", int'(state), 2);
    send_ref(base + 100, 0, 1'b0, 1'b1);
    wait_until(base + 110);
    check("oneshot_period", last_rise, base + 103);
    send_ref(base + 205, 5, 1'b1, 1'b1);
    wait_until(base + 215);
    check("oneshot_outlier_fall", last_fall, base + 213);
    send_ref(base + 302, 2, 1'b0, 1'b1);
    wait_until(base + 315);
    check("oneshot_noshift_fall", last_fall, base + 313);
    check("oneshot_no_holdover", ho_rise, -1);

    // track mode
    rst_n = 1'b0; mode = 2'b01;
    tick(2);
    rst_n = 1'b1;
    last_rise = -1; last_fall = -1; last_len = -1; ho_rise = -1;
    tick(2);
    check("track_wait", int'(state), 1);
    n = cyc + 2;
    send_ref(n, 0, 1'b0, 1'b0);
    wait_until(n + 15);
    check("track_first_rise", last_rise, n + 3);
    send_ref(n + 100, 0, 1'b0, 1'b1); n += 100;
    wait_until(n + 15);
    check("track_on_time", last_rise, n + 3);
    send_ref(n + 102, 2, 1'b0, 1'b1); n += 102;
    wait_until(n + 15);
    check("late2_rise", last_rise, n + 1);
    check("late2_fall", last_fall, n + 13);
    check("late2_len", last_len, 12);
    send_ref(n + 97, -3, 1'b0, 1'b1); n += 97;
    wait_until(n + 15);
    check("early3_rise", last_rise, n + 3);
    check("early3_len", last_len, PULSE);
    send_ref(n + 105, 5, 1'b1, 1'b1);
    wait_until(n + 120);
    check("outlier_noshift_fall", last_fall, n + 113);
    check("holdover_time", ho_rise, n + 106);
    check("hold_state", int'(state), 3);
    check("holdover_level", int'(holdover), 1);
    wait_until(n + 215);
    check("holdover_pps", last_rise, n + 203);
    check("holdover_still", int'(holdover), 1);
    send_ref(n + 301, 1, 1'b0, 1'b1); n += 301;
    wait_until(n + 15);
    check("return_rise", last_rise, n + 2);
    check("return_len", last_len, 11);
    check("return_holdover", int'(holdover), 0);
    check("return_state", int'(state), 2);
    send_ref(n + 100, 0, 1'b0, 1'b1); n += 100;
    wait_until(n + 15);
    check("realigned", last_rise, n + 3);

    // coincident stop and reference, then free-run
    r = n + 104;
    wait_until(r);
    pps_ref = 1'b1; div_rst = 1'b1; mode = 2'b10;
    tick(2);
    check("coinc_pps_before", int'(pps_out), 1);
    tick(1);
    check("stop_pps", int'(pps_out), 0);
    check("stop_state", int'(state), 0);
    check("stop_err_held", int'(phase_err), 0);
    tick(1);
    pps_ref = 1'b0;
    check("free_start", int'(state), 2);
    check("free_pps", int'(pps_out), 1);
    f = cyc;
    send_ref(f + 95, -2, 1'b0, 1'b1);
    wait_until(f + 115);
    check("free_noshift", last_rise, f + 100);
    check("free_len", last_len, PULSE);
    check("free_no_holdover", int'(holdover), 0);

    // asynchronous reset in the middle of a pulse
    wait_until(f + 205);
    check("pre_reset_pps", int'(pps_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pps", int'(pps_out), 0);
    check("midrst_state", int'(state), 0);
    check("midrst_valid", int'(phase_valid), 0);
    check("midrst_outlier", int'(outlier), 0);
    check("midrst_holdover", int'(holdover), 0);
    check("midrst_err", int'(phase_err), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("release_free_state", int'(state), 2);
    check("release_free_pps", int'(pps_out), 1);
    arm = 1'b0;
    tick(1);
    check("disarm_state", int'(state), 0);
    check("disarm_pps", int'(pps_out), 0);
    tick(5);
    check("pending_meas", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
